// File: rtl/sequential_shift_right.sv
// -----------------------------------------------------------------------------
// sequential_shift_right
//
// Multi-cycle right-shift unit for the ALU path (SRL/SRA/SRLV/SRAV). One
// register and one down-counter are shared: the operand moves one bit
// position per clock instead of passing through a full barrel shifter.
// The controller pulses start_i and waits for done_o, then reads out_o.
//
// Ports
//   clk_i     rising-edge clock, single clock domain
//   reset_i   synchronous, active-high reset (wins over start_i)
//   start_i   request; accepted only while busy_o == 0
//   op_i      00 SRL, 01 SRA, 10 ROTR (SHR_ROTATE_EN only, else SRL),
//             11 reserved (SRL)
//   in_i      operand, latched on an accepted start
//   shamt_i   shift amount, latched on an accepted start
//   busy_o    operation in progress (state == SHIFT)
//   done_o    one-cycle pulse; out_o holds the new result in that cycle
//   out_o     result register; holds until the next done_o or reset
//
// Configuration
//   SHR_ROTATE_EN  when defined, op 10 rotates right; when undefined it
//                  behaves as SRL and no rotate logic exists.
//
// Timing: start accepted at edge E -> done_o=1 and out_o valid after edge
// E+shamt+1; busy_o is high from after E until that same edge.
// -----------------------------------------------------------------------------
module sequential_shift_right #(
    parameter int DATA_SIZE  = 32,
    parameter int SHAMT_SIZE = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_SIZE-1:0]  in_i,
    input  logic [SHAMT_SIZE-1:0] shamt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_SIZE-1:0]  out_o
);

    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_SIZE-1:0]  acc_q,   acc_d;
    logic [SHAMT_SIZE-1:0] cnt_q,   cnt_d;
    logic [1:0]            op_q,    op_d;
    logic [DATA_SIZE-1:0]  out_q,   out_d;
    logic                  done_q,  done_d;

    // One right-shift step: only the bit entering at the MSB depends on op.
    function automatic logic [DATA_SIZE-1:0] shift_step(
        input logic [DATA_SIZE-1:0] acc,
        input logic [1:0]           op
    );
        logic fill;
        fill = 1'b0;
        case (op)
            OP_SRA:  fill = acc[DATA_SIZE-1];
`ifdef SHR_ROTATE_EN
            OP_ROTR: fill = acc[0];
`else
            OP_ROTR: fill = 1'b0;
`endif
            default: fill = 1'b0;
        endcase
        return {fill, acc[DATA_SIZE-1:1]};
    endfunction

    // Next-state and datapath decode; holds everything unless the FSM acts.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    acc_d   = in_i;
                    cnt_d   = shamt_i;
                    op_d    = op_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == {SHAMT_SIZE{1'b0}}) begin
                    // Final edge: publish result; a start in the following
                    // cycle is seen in IDLE, giving back-to-back operation.
                    state_d = ST_IDLE;
                    out_d   = acc_q;
                    done_d  = 1'b1;
                end else begin
                    acc_d = shift_step(acc_q, op_q);
                    cnt_d = cnt_q - SHAMT_SIZE'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= {DATA_SIZE{1'b0}};
            cnt_q   <= {SHAMT_SIZE{1'b0}};
            op_q    <= 2'b00;
            out_q   <= {DATA_SIZE{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = done_q;
    assign out_o  = out_q;

endmodule
